ddr3_app_master: RTL and testbench

DDR3_APP_MASTER -- requirements
Module: ddr3_app_master

---
 rtl/ddr3_app_pkg.sv | 16 +
 rtl/ddr3_rsp_fifo.sv | 60 ++++++
 rtl/ddr3_app_master.sv | 127 ++++++++++++
 tb/tb_ddr3_app_master.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_app_pkg.sv
// rtl/ddr3_app_pkg.sv - shared DDR3 application-interface widths, command codes and FSM states
package ddr3_app_pkg;
   localparam int DDR3_ADDR_W = 28;
   localparam int DDR3_DATA_W = 512;
   localparam int DDR3_MASK_W = DDR3_DATA_W / 8;

   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_WR,
      ST_RD
   } app_state_t;
endpackage

// File: rtl/ddr3_rsp_fifo.sv
// rtl/ddr3_rsp_fifo.sv - read-response buffer; push and pop may coincide even when full
module ddr3_rsp_fifo #(
   parameter int DATA_W = 512,
   parameter int DEPTH  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              empty,
   output logic              overflow
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              do_push;
   logic              do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   // Masked head keeps the response data at zero whenever nothing is buffered.
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push && !do_push) overflow <= 1'b1;
      end
   end
endmodule

// File: rtl/ddr3_app_master.sv
// rtl/ddr3_app_master.sv - user request/response front end for a DDR3 controller app interface
module ddr3_app_master
   import ddr3_app_pkg::*;
#(
   parameter int ADDR_W    = DDR3_ADDR_W,
   parameter int DATA_W    = DDR3_DATA_W,
   parameter int MASK_W    = DDR3_MASK_W,
   parameter int RSP_DEPTH = 8
) (
   input  logic              ui_clk,
   input  logic              ui_clk_sync_rst,
   input  logic              init_calib_complete,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   input  logic [MASK_W-1:0] req_mask,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] app_addr,
   output logic [2:0]        app_cmd,
   output logic              app_en,
   input  logic              app_rdy,
   output logic [DATA_W-1:0] app_wdf_data,
   output logic [MASK_W-1:0] app_wdf_mask,
   output logic              app_wdf_wren,
   output logic              app_wdf_end,
   input  logic              app_wdf_rdy,
   input  logic [DATA_W-1:0] app_rd_data,
   input  logic              app_rd_data_valid,
   input  logic              app_rd_data_end,
   output logic              err_overflow
);
   localparam int CRED_W = $clog2(RSP_DEPTH + 1);

   app_state_t        state;
   app_state_t        state_next;
   logic [CRED_W-1:0] credits;
   logic              accept;
   logic              en_hs;
   logic              wr_hs;
   logic              rd_issued;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic              unused_sig;

   // Credits bound outstanding reads so returning data always has a buffer slot.
   assign req_ready   = (state == ST_IDLE) && init_calib_complete && (credits < CRED_W'(RSP_DEPTH));
   assign accept      = req_valid && req_ready;
   assign en_hs       = app_en && app_rdy;
   assign wr_hs       = app_wdf_wren && app_wdf_rdy;
   assign rd_issued   = (state == ST_RD) && en_hs;
   assign app_wdf_end = app_wdf_wren;
   assign rsp_valid   = !fifo_empty;
   assign pop         = rsp_valid && rsp_ready;
   assign unused_sig  = ^{app_rd_data_end, fifo_full};

   always_ff @(posedge ui_clk) begin
      if (ui_clk_sync_rst) state <= ST_INIT;
      else                 state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_INIT: if (init_calib_complete) state_next = ST_IDLE;
         ST_IDLE: begin
            if (!init_calib_complete) state_next = ST_INIT;
            else if (accept)          state_next = req_write ? ST_WR : ST_RD;
         end
         ST_WR:   if ((!app_en || app_rdy) && (!app_wdf_wren || app_wdf_rdy)) state_next = ST_IDLE;
         ST_RD:   if (en_hs) state_next = ST_IDLE;
         default: state_next = ST_INIT;
      endcase
   end

   always_ff @(posedge ui_clk) begin
      if (ui_clk_sync_rst) begin
         app_addr     <= '0;
         app_cmd      <= '0;
         app_wdf_data <= '0;
         app_wdf_mask <= '0;
         app_en       <= 1'b0;
         app_wdf_wren <= 1'b0;
      end else if (accept) begin
         app_addr     <= req_addr;
         app_cmd      <= req_write ? CMD_WRITE : CMD_READ;
         app_wdf_data <= req_data;
         app_wdf_mask <= req_mask;
         app_en       <= 1'b1;
         app_wdf_wren <= req_write;
      end else begin
         if (en_hs) app_en       <= 1'b0;
         if (wr_hs) app_wdf_wren <= 1'b0;
      end
   end

   always_ff @(posedge ui_clk) begin
      if (ui_clk_sync_rst) begin
         credits <= '0;
      end else begin
         case ({rd_issued, pop && (credits != '0)})
            2'b10:   credits <= credits + 1'b1;
            2'b01:   credits <= credits - 1'b1;
            default: credits <= credits;
         endcase
      end
   end

   ddr3_rsp_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk       (ui_clk),
      .rst       (ui_clk_sync_rst),
      .push      (app_rd_data_valid),
      .push_data (app_rd_data),
      .pop       (pop),
      .head      (rsp_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .overflow  (err_overflow)
   );
endmodule

// File: tb/tb_ddr3_app_master.sv
// tb/tb_ddr3_app_master.sv - scoreboard bench for ddr3_app_master
module tb_ddr3_app_master;
   import ddr3_app_pkg::*;

   localparam int AW = 28;
   localparam int DW = 512;
   localparam int MW = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          calib;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_data;
   logic [MW-1:0] req_mask;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;
   logic [AW-1:0] app_addr;
   logic [2:0]    app_cmd;
   logic          app_en;
   logic          app_rdy;
   logic [DW-1:0] app_wdf_data;
   logic [MW-1:0] app_wdf_mask;
   logic          app_wdf_wren;
   logic          app_wdf_end;
   logic          app_wdf_rdy;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          rd_end;
   logic          err_overflow;

   always #5 clk = ~clk;

   ddr3_app_master dut (
      .ui_clk              (clk),
      .ui_clk_sync_rst     (rst),
      .init_calib_complete (calib),
      .req_valid           (req_valid),
      .req_ready           (req_ready),
      .req_write           (req_write),
      .req_addr            (req_addr),
      .req_data            (req_data),
      .req_mask            (req_mask),
      .rsp_valid           (rsp_valid),
      .rsp_ready           (rsp_ready),
      .rsp_data            (rsp_data),
      .app_addr            (app_addr),
      .app_cmd             (app_cmd),
      .app_en              (app_en),
      .app_rdy             (app_rdy),
      .app_wdf_data        (app_wdf_data),
      .app_wdf_mask        (app_wdf_mask),
      .app_wdf_wren        (app_wdf_wren),
      .app_wdf_end         (app_wdf_end),
      .app_wdf_rdy         (app_wdf_rdy),
      .app_rd_data         (rd_data),
      .app_rd_data_valid   (rd_valid),
      .app_rd_data_end     (rd_end),
      .err_overflow        (err_overflow)
   );

   int checks   = 0;
   int failures = 0;

   logic [AW-1:0] exp_addr_q [$];
   logic [2:0]    exp_cmd_q [$];
   logic [DW-1:0] exp_wdata_q [$];
   logic [MW-1:0] exp_wmask_q [$];
   logic [DW-1:0] exp_rsp_q [$];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s: event not expected or not seen", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Command, write-data and response monitors
   always @(negedge clk) begin
      if (!rst) begin
         if (app_en && app_rdy) begin
            if (exp_addr_q.size() == 0) fail("cmd_unexpected");
            else begin
               check("cmd_addr", app_addr, exp_addr_q.pop_front());
               check("cmd_code", app_cmd, exp_cmd_q.pop_front());
            end
         end
         if (app_wdf_wren && app_wdf_rdy) begin
            if (exp_wdata_q.size() == 0) fail("wdata_unexpected");
            else begin
               check("wdf_data", app_wdf_data, exp_wdata_q.pop_front());
               check("wdf_mask", app_wdf_mask, exp_wmask_q.pop_front());
               check("wdf_end", app_wdf_end, 1'b1);
            end
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_rsp_q.size() == 0) fail("rsp_unexpected");
            else check("rsp_data", rsp_data, exp_rsp_q.pop_front());
         end
      end
   end

   task automatic send_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [MW-1:0] m, input logic expect_hs, output int waits);
      if (expect_hs) begin
         exp_addr_q.push_back(a);
         exp_cmd_q.push_back(wr ? CMD_WRITE : CMD_READ);
         if (wr) begin
            exp_wdata_q.push_back(d);
            exp_wmask_q.push_back(m);
         end
      end
      req_write = wr;
      req_addr  = a;
      req_data  = d;
      req_mask  = m;
      req_valid = 1'b1;
      waits     = 0;
      @(negedge clk);
      while (!req_ready && waits < 50) begin
         waits++;
         @(negedge clk);
      end
      if (!req_ready) fail("req_accept_timeout");
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (dut.state != ST_IDLE && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (dut.state != ST_IDLE) fail("wait_idle_timeout");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      int waits;
      rst = 1'b1; calib = 1'b0; req_valid = 1'b0; req_write = 1'b0;
      req_addr = '0; req_data = '0; req_mask = '0;
      app_rdy = 1'b1; app_wdf_rdy = 1'b1; rd_valid = 1'b0; rd_data = '0; rd_end = 1'b0; rsp_ready = 1'b0;
      repeat (3) tick();

      @(negedge clk);
      check("rst_req_ready", req_ready, 1'b0);
      check("rst_app_en", app_en, 1'b0);
      check("rst_wren", app_wdf_wren, 1'b0);
      check("rst_wdf_end", app_wdf_end, 1'b0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_err", err_overflow, 1'b0);
      check("rst_addr", app_addr, '0);
      check("rst_cmd", app_cmd, '0);
      check("rst_wdata", app_wdf_data, '0);
      check("rst_wmask", app_wdf_mask, '0);
      check("rst_rsp_data", rsp_data, '0);
      check("rst_state", dut.state, ST_INIT);
      check("rst_credits", dut.credits, '0);

      // Calibration gating
      tick();
      rst = 1'b0;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 28'h0000200;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("calib_req_ready", req_ready, 1'b0);
         check("calib_app_en", app_en, 1'b0);
      end
      tick();
      calib = 1'b1;
      send_req(1'b1, 28'h0000200, DW'(128'hDEAD_BEEF_0123_4567_89AB_CDEF_1122_3344),
               64'h0000_0000_0000_FFFF, 1'b1, waits);
      check("calib_accept_latency", (waits <= 2), 1'b1);
      wait_idle();

      // Write with command-channel stall
      tick();
      app_rdy = 1'b0;
      send_req(1'b1, 28'h0000100, DW'(64'hCAFE_F00D_5555_AAAA), '0, 1'b1, waits);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("stall_app_en", app_en, 1'b1);
         check("stall_addr", app_addr, 28'h0000100);
         check("stall_wren", app_wdf_wren, (i == 0));
         tick();
         if (i == 2) app_rdy = 1'b1;
      end
      @(negedge clk);
      check("stall_state_idle", dut.state, ST_IDLE);
      check("stall_en_low", app_en, 1'b0);

      // Read burst up to the credit limit
      tick();
      for (int i = 0; i < 8; i++) send_req(1'b0, AW'(i * 8), '0, '0, 1'b1, waits);
      wait_idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("credit_limit_ready", req_ready, 1'b0);
      end
      check("credit_limit_count", dut.credits, 8);
      for (int i = 0; i < 8; i++) begin
         tick();
         rd_valid = 1'b1;
         rd_data  = DW'(8'hA0 + i);
         exp_rsp_q.push_back(rd_data);
      end
      tick();
      rd_valid = 1'b0;
      @(negedge clk);
      check("burst_full", dut.fifo_full, 1'b1);
      check("burst_rsp_valid", rsp_valid, 1'b1);
      check("burst_err", err_overflow, 1'b0);

      // Simultaneous push and pop on a full buffer, then a forced overflow
      tick();
      rd_valid = 1'b1; rd_data = DW'(8'hB0); exp_rsp_q.push_back(rd_data); rsp_ready = 1'b1;
      tick();
      rd_valid = 1'b1; rd_data = DW'(8'hEE); rsp_ready = 1'b0;
      @(negedge clk);
      check("sim_full_kept", dut.fifo_full, 1'b1);
      check("sim_no_err", err_overflow, 1'b0);
      check("req_ready_after_pop", req_ready, 1'b1);
      tick();
      rd_valid = 1'b0;
      @(negedge clk);
      check("ovf_set", err_overflow, 1'b1);
      tick(); tick();
      @(negedge clk);
      check("ovf_sticky", err_overflow, 1'b1);
      tick();
      rsp_ready = 1'b1;
      for (int n = 0; n < 20 && exp_rsp_q.size() != 0; n++) tick();
      rsp_ready = 1'b0;
      @(negedge clk);
      check("drain_empty", rsp_valid, 1'b0);
      check("drain_err_sticky", err_overflow, 1'b1);

      // Reset in the middle of a stalled write
      tick();
      send_req(1'b0, 28'h0000080, '0, '0, 1'b1, waits);
      wait_idle();
      tick();
      app_rdy = 1'b0; app_wdf_rdy = 1'b0;
      send_req(1'b1, 28'h0000300, DW'(32'h1234_5678), '0, 1'b0, waits);
      @(negedge clk);
      check("midwr_app_en", app_en, 1'b1);
      check("midwr_wren", app_wdf_wren, 1'b1);
      tick();
      rst = 1'b1;
      tick();
      @(negedge clk);
      check("rstwr_app_en", app_en, 1'b0);
      check("rstwr_wren", app_wdf_wren, 1'b0);
      check("rstwr_state", dut.state, ST_INIT);
      check("rstwr_credits", dut.credits, '0);
      check("rstwr_err", err_overflow, 1'b0);
      tick();
      rst = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      repeat (3) tick();

      check("left_cmds", exp_addr_q.size(), 0);
      check("left_wdata", exp_wdata_q.size(), 0);
      check("left_rsp", exp_rsp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
